// File: rtl/inst_prefetch_queue.sv
// Instruction fetch front end. It issues sequential fetch requests, keeps a bounded
// number in flight, and queues returned instructions in order for decode. A redirect
// flushes the queue and marks every in-flight request stale.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] PC,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ready,
    input  logic [31:0] Instruction,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_drop_cnt,
    output logic [31:0] perf_stall_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic          req_valid_q, req_valid_d;
    logic [31:0]   pc_q, pc_d;
    logic          pend_q, pend_d;
    logic [31:0]   pend_pc_q, pend_pc_d;
    logic          held_stale_q, held_stale_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_q, drop_d;

    logic [31:0]   tag_q [MAX_OUTSTANDING];
    logic [TW-1:0] tag_wr_q, tag_rd_q;

    logic [31:0]   qpc_q   [DEPTH];
    logic [31:0]   qinst_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   req_cnt_q, drop_cnt_q, stall_cnt_q;

    logic          req_hs, resp_hs, drop_now, push, pop, issue_ok;
    logic [31:0]   redir_pc;

    assign Inst_Ready = rst_n;
    assign req_hs     = req_valid_q & Inst_Req_Ready;
    assign resp_hs    = Inst_Valid & Inst_Ready;
    assign drop_now   = resp_hs & (drop_q != '0);
    assign out_valid  = (cnt_q != '0);
    // A redirect flushes the queue, so any push or pop in that cycle is ignored.
    assign push       = resp_hs & ~drop_now & ~redirect_valid;
    assign pop        = out_valid & out_ready & ~redirect_valid;
    assign redir_pc   = redirect_pc & ~32'h3;

    // Credit bookkeeping: in-flight count, stale count, queue occupancy and issue decision.
    always_comb begin
        outst_d = outst_q + OW'(req_hs) - OW'(resp_hs);
        cnt_d   = redirect_valid ? '0 : (cnt_q + CW'(push) - CW'(pop));
        if (redirect_valid) begin
            // Everything still in flight after this edge is stale.
            drop_d = outst_d;
        end else begin
            // A held request that was redirected becomes stale once it is accepted.
            drop_d = drop_q - OW'(drop_now) + OW'(req_hs & held_stale_q);
        end
        issue_ok    = (32'(outst_d) + 32'(cnt_d) < DEPTH) && (32'(outst_d) < MAX_OUTSTANDING);
        req_valid_d = (req_valid_q & ~req_hs) | issue_ok;
    end

    // Next fetch address, including a redirect deferred behind a held request.
    always_comb begin
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        held_stale_d = held_stale_q;
        if (req_hs) begin
            pend_d       = 1'b0;
            held_stale_d = 1'b0;
            if (redirect_valid) begin
                pc_d = redir_pc;
            end else if (pend_q) begin
                pc_d = pend_pc_q;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else if (redirect_valid) begin
            if (req_valid_q) begin
                pend_d       = 1'b1;
                pend_pc_d    = redir_pc;
                held_stale_d = 1'b1;
            end else begin
                pc_d = redir_pc;
            end
        end
    end

    // Request channel and credit state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid_q  <= 1'b0;
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
            held_stale_q <= 1'b0;
            outst_q      <= '0;
            drop_q       <= '0;
            cnt_q        <= '0;
        end else begin
            req_valid_q  <= req_valid_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            held_stale_q <= held_stale_d;
            outst_q      <= outst_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
        end
    end

    // Tag FIFO of issued PCs; popped by every response, stale or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) tag_q[i] <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            if (req_hs) begin
                tag_q[tag_wr_q] <= pc_q;
                tag_wr_q <= (tag_wr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + 1'b1;
            end
            if (resp_hs) begin
                tag_rd_q <= (tag_rd_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + 1'b1;
            end
        end
    end

    // In-order instruction queue; a flush just moves the read pointer onto the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                qpc_q[i]   <= '0;
                qinst_q[i] <= '0;
            end
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) begin
                qpc_q[wr_q]   <= tag_q[tag_rd_q];
                qinst_q[wr_q] <= Instruction;
                wr_q          <= wr_q + 1'b1;
            end
            if (redirect_valid) begin
                rd_q <= wr_q;
            end else if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    // Free-running performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (req_hs)                 req_cnt_q   <= req_cnt_q + 32'd1;
            if (drop_now)               drop_cnt_q  <= drop_cnt_q + 32'd1;
            if (out_ready && !out_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign PC             = pc_q;
    assign Inst_Req_Valid = req_valid_q;
    assign out_pc         = out_valid ? qpc_q[rd_q] : '0;
    assign out_inst       = out_valid ? qinst_q[rd_q] : '0;
    assign perf_req_cnt   = req_cnt_q;
    assign perf_drop_cnt  = drop_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios, a queue-based reference model
// compared every cycle, and literal expectations for each scenario.
module tb_inst_prefetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_drop_cnt;
    logic [31:0] perf_stall_cnt;

    logic        resp_en;
    int          n_checks = 0;
    int          n_errors = 0;

    // Memory responder and delivered-stream log
    logic [31:0] rq[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_inst[$];

    // Reference model state
    logic        m_req_valid = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    logic        m_held_stale = 1'b0;
    logic [31:0] f_pc[$];
    bit          f_st[$];
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    logic [31:0] m_req = 0, m_drop = 0, m_stall = 0;

    inst_prefetch_queue #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .PC(PC),
        .Inst_Req_Valid(Inst_Req_Valid),
        .Inst_Req_Ready(Inst_Req_Ready),
        .Instruction(Instruction),
        .Inst_Valid(Inst_Valid),
        .Inst_Ready(Inst_Ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_inst(out_inst),
        .perf_req_cnt(perf_req_cnt),
        .perf_drop_cnt(perf_drop_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    // Delivered PCs must be base, base+4, ... with inst = pc ^ 0xFFFF
    task automatic chk_stream(input string name, input logic [31:0] base, input int n);
        chk({name, "_len"}, 32'(dlv_pc.size() >= n), 32'd1);
        for (int i = 0; i < n && i < dlv_pc.size(); i++) begin
            chk({name, "_pc"}, dlv_pc[i], base + 32'(4 * i));
            chk({name, "_inst"}, dlv_inst[i], (base + 32'(4 * i)) ^ 32'hFFFF);
        end
    endtask

    // One clock of the reference model, in terms of in-flight and queued transactions
    task automatic model_step();
        bit          req_hs;
        logic [31:0] rpc;
        logic [31:0] tpc;
        bit          tst;
        if (!rst_n) begin
            m_req_valid = 1'b0; m_pc = 32'h0; m_pend = 1'b0; m_pend_pc = 32'h0;
            m_held_stale = 1'b0;
            f_pc.delete(); f_st.delete(); q_pc.delete(); q_inst.delete();
            m_req = 0; m_drop = 0; m_stall = 0;
            return;
        end
        rpc    = redirect_pc & ~32'h3;
        req_hs = m_req_valid && Inst_Req_Ready;
        if (out_ready && q_pc.size() == 0) m_stall++;
        if (out_ready && q_pc.size() != 0 && !redirect_valid) begin
            void'(q_pc.pop_front());
            void'(q_inst.pop_front());
        end
        if (Inst_Valid && f_pc.size() != 0) begin
            tpc = f_pc.pop_front();
            tst = f_st.pop_front();
            if (tst) m_drop++;
            else if (!redirect_valid) begin
                q_pc.push_back(tpc);
                q_inst.push_back(Instruction);
            end
        end
        if (req_hs) begin
            f_pc.push_back(m_pc);
            f_st.push_back(m_held_stale);
            m_req++;
        end
        if (redirect_valid) begin
            foreach (f_st[i]) f_st[i] = 1'b1;
            q_pc.delete();
            q_inst.delete();
        end
        if (req_hs) begin
            if (redirect_valid) m_pc = rpc;
            else if (m_pend) m_pc = m_pend_pc;
            else m_pc = m_pc + 32'd4;
            m_pend = 1'b0;
            m_held_stale = 1'b0;
        end else if (redirect_valid) begin
            if (m_req_valid) begin
                m_pend = 1'b1; m_pend_pc = rpc; m_held_stale = 1'b1;
            end else begin
                m_pc = rpc;
            end
        end
        if (!(m_req_valid && !req_hs)) begin
            m_req_valid = (f_pc.size() + q_pc.size() < DEPTH) && (f_pc.size() < MAXO);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Memory: answers each accepted request one cycle later unless held off by resp_en
    initial forever begin
        @(posedge clk);
        if (!rst_n) rq.delete();
        else begin
            if (Inst_Valid && Inst_Ready) void'(rq.pop_front());
            if (Inst_Req_Valid && Inst_Req_Ready) rq.push_back(PC);
        end
        #2;
        if (rst_n && resp_en && rq.size() != 0) begin
            Inst_Valid  = 1'b1;
            Instruction = rq[0] ^ 32'hFFFF;
        end else begin
            Inst_Valid  = 1'b0;
            Instruction = 32'h0;
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst_n && out_valid && out_ready) begin
            dlv_pc.push_back(out_pc);
            dlv_inst.push_back(out_inst);
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("req_valid", 32'(Inst_Req_Valid), 32'(m_req_valid));
            chk("pc", PC, m_pc);
            chk("inst_ready", 32'(Inst_Ready), 32'd1);
            chk("out_valid", 32'(out_valid), 32'(q_pc.size() != 0));
            if (q_pc.size() != 0) begin
                chk("out_pc", out_pc, q_pc[0]);
                chk("out_inst", out_inst, q_inst[0]);
            end
            chk("perf_req", perf_req_cnt, m_req);
            chk("perf_drop", perf_drop_cnt, m_drop);
            chk("perf_stall", perf_stall_cnt, m_stall);
        end
    end

    initial begin
        rst_n = 1'b0; Inst_Req_Ready = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; resp_en = 1'b1;
        Inst_Valid = 1'b0; Instruction = 32'h0;
        tick(2);
        chk("rst_req_valid", 32'(Inst_Req_Valid), 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_inst_ready", 32'(Inst_Ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_perf_req", perf_req_cnt, 32'h0);
        chk("rst_perf_drop", perf_drop_cnt, 32'h0);
        chk("rst_perf_stall", perf_stall_cnt, 32'h0);

        // Streaming with one-cycle responses and decode always ready
        rst_n = 1'b1; Inst_Req_Ready = 1'b1; out_ready = 1'b1;
        tick(12);
        chk_stream("stream", 32'h0, 4);

        // Decode stalled: four requests fill the queue, then issue stops
        out_ready = 1'b0;
        do_reset();
        tick(6);
        chk("full_req_cnt", perf_req_cnt, 32'd4);
        chk("full_req_valid", 32'(Inst_Req_Valid), 32'd0);
        chk("full_pc", PC, 32'h10);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_out_pc", out_pc, 32'h0);
        chk("full_out_inst", out_inst, 32'h0000_FFFF);
        dlv_pc.delete(); dlv_inst.delete();
        out_ready = 1'b1;
        tick(10);
        chk_stream("drain", 32'h0, 5);

        // Two requests in flight when a redirect arrives
        resp_en = 1'b0;
        do_reset();
        tick(3);
        chk("infl_req_valid", 32'(Inst_Req_Valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick(1);
        redirect_valid = 1'b0; resp_en = 1'b1;
        chk("redir_pc", PC, 32'h100);
        dlv_pc.delete(); dlv_inst.delete();
        tick(8);
        chk("redir_drops", perf_drop_cnt, 32'd2);
        chk_stream("redir", 32'h100, 1);

        // Redirect while a request at 0x8 is held, with a response and pop in the same cycle
        do_reset();
        tick(3);
        chk("held_req_valid", 32'(Inst_Req_Valid), 32'd1);
        chk("held_pc", PC, 32'h8);
        Inst_Req_Ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick(1);
        redirect_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        dlv_pc.delete(); dlv_inst.delete();
        tick(2);
        chk("held_pc2", PC, 32'h8);
        chk("held_req_valid2", 32'(Inst_Req_Valid), 32'd1);
        Inst_Req_Ready = 1'b1;
        tick(8);
        chk("held_drops", perf_drop_cnt, 32'd1);
        chk_stream("held", 32'h100, 1);

        // Reset while the queue holds three entries
        out_ready = 1'b0;
        do_reset();
        tick(5);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(Inst_Req_Valid), 32'd0);
        chk("mid_rst_pc", PC, 32'h0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_pc", out_pc, 32'h0);
        chk("mid_rst_inst_ready", 32'(Inst_Ready), 32'd0);
        chk("mid_rst_perf_req", perf_req_cnt, 32'h0);
        tick(1);
        rst_n = 1'b1; out_ready = 1'b1;
        dlv_pc.delete(); dlv_inst.delete();
        tick(8);
        chk_stream("restart", 32'h0, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
